// File: rtl/contador_mod_updown_pkg.sv
// Shared definitions for the contador_mod_updown counter: direction encodings,
// the terminal-value helper and the parameter-legality check used at elaboration.
package contador_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest legal counter is 16 bits, so 17 bits covers WIDTH+1 arithmetic.
  localparam int MAX_WIDTH = 16;

  // Value at which the counter wraps for the given direction.
  function automatic logic [MAX_WIDTH:0] term_value(input logic dir, input int unsigned modulus);
    if (dir == DIR_UP) begin
      return (MAX_WIDTH+1)'(modulus - 1);
    end
    return '0;
  endfunction

  // True when WIDTH is 2..16 and MODULUS is 2..2**WIDTH.
  function automatic bit params_ok(input int width, input int modulus);
    if (width < 2 || width > MAX_WIDTH) return 1'b0;
    if (modulus < 2 || modulus > (1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/contador_mod_updown_if.sv
// Control and status bundle of contador_mod_updown.
// No valid/ready handshake here: en and load are level strobes sampled on every
// rising clk edge; q, q_gray and wrap are registered, tc is combinational.
interface contador_mod_updown_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             w;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_gray;
  logic             tc;
  logic             wrap;

  modport master (output en, w, load, d, input q, q_gray, tc, wrap);
  modport slave  (input en, w, load, d, output q, q_gray, tc, wrap);
endinterface

// File: rtl/contador_mod_updown_bin2gray.sv
// Combinational binary-to-Gray converter.
module bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of neighbouring binary bits.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/contador_mod_updown.sv
// Parametrised up/down modulo counter with enable, parallel load, terminal
// count, registered wrap pulse and registered Gray copy of the count.
// Build option: define CONTADOR_SAT_EN for saturating instead of wrapping.
module contador_mod_updown
  import contador_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  contador_mod_updown_if.slave  bus
);

  localparam int                CW    = WIDTH + 1;
  localparam logic [WIDTH:0]    MOD_X = CW'(MODULUS);
  localparam logic [WIDTH-1:0]  MAX_Q = WIDTH'(MODULUS - 1);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("contador_mod_updown: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   q_x, d_x, term_x;
  logic             at_term;

  // Compare at WIDTH+1 bits so MODULUS=2**WIDTH is representable.
  assign q_x     = {1'b0, q_q};
  assign d_x     = {1'b0, bus.d};
  assign term_x  = CW'(term_value(bus.w, MODULUS));
  assign at_term = (q_x == term_x);

  // Terminal count ignores load on purpose.
  assign bus.tc = bus.en & at_term;

  // Next count: load beats enable; terminal value wraps (or saturates).
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = (d_x < MOD_X) ? bus.d : MAX_Q;
    end else if (bus.en) begin
      if (at_term) begin
`ifdef CONTADOR_SAT_EN
        q_d = q_q;
`else
        q_d    = (bus.w == DIR_UP) ? '0 : MAX_Q;
        wrap_d = 1'b1;
`endif
      end else if (bus.w == DIR_UP) begin
        q_d = WIDTH'(q_x + CW'(1));
      end else begin
        q_d = WIDTH'(q_x - CW'(1));
      end
    end
  end

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin  (q_d),
    .gray (gray_d)
  );

  // Count, Gray copy and wrap pulse all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.q_gray = gray_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_contador_mod_updown.sv
// Directed bench for contador_mod_updown: one WIDTH=3/MODULUS=8 instance and one
// WIDTH=3/MODULUS=6 instance, driven from hand-computed vector tables.
module tb_contador_mod_updown;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  contador_mod_updown_if #(.WIDTH(3)) if8 ();
  contador_mod_updown_if #(.WIDTH(3)) if6 ();

  contador_mod_updown #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  contador_mod_updown #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (if6)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic       w;
    logic       load;
    logic [2:0] d;
    logic       chk_tc;
    logic       exp_tc;
    logic [2:0] exp_q;
    logic [2:0] exp_gray;
    logic       exp_wrap;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic dir,
                              input logic ld, input logic [2:0] dv,
                              input logic ct, input logic t,
                              input logic [2:0] q, input logic [2:0] g,
                              input logic wr);
    vec_t v;
    v.rst = r; v.en = e; v.w = dir; v.load = ld; v.d = dv;
    v.chk_tc = ct; v.exp_tc = t; v.exp_q = q; v.exp_gray = g; v.exp_wrap = wr;
    return v;
  endfunction

  vec_t tab8[$];
  vec_t tab6[$];

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one vector on the selected instance (the other idles), check tc
  // before the edge and the registered outputs #1 after it.
  task automatic run_vec(input bit sel8, input string tag, input int idx, input vec_t v);
    logic [2:0] eq;
    logic [2:0] aq, ag;
    logic       at, aw;
    rst = v.rst;
    if (sel8) begin
      if8.en = v.en; if8.w = v.w; if8.load = v.load; if8.d = v.d;
      if6.en = 1'b0; if6.load = 1'b0;
    end else begin
      if6.en = v.en; if6.w = v.w; if6.load = v.load; if6.d = v.d;
      if8.en = 1'b0; if8.load = 1'b0;
    end
    #1;
    at = sel8 ? if8.tc : if6.tc;
    if (v.chk_tc) chk({tag, "_tc"}, idx, 32'(at), 32'(v.exp_tc));
    exp_q.push_back(v.exp_q);
    @(posedge clk);
    #1;
    aq = sel8 ? if8.q      : if6.q;
    ag = sel8 ? if8.q_gray : if6.q_gray;
    aw = sel8 ? if8.wrap   : if6.wrap;
    eq = exp_q.pop_front();
    chk({tag, "_q"},    idx, 32'(aq), 32'(eq));
    chk({tag, "_gray"}, idx, 32'(ag), 32'(v.exp_gray));
    chk({tag, "_wrap"}, idx, 32'(aw), 32'(v.exp_wrap));
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    if8.en = 1'b0; if8.w = 1'b0; if8.load = 1'b0; if8.d = '0;
    if6.en = 1'b0; if6.w = 1'b0; if6.load = 1'b0; if6.d = '0;

    //                rst en w  ld d  ct tc q  g  wrap
    // MODULUS=8: reset held two cycles with en=1,w=1, then count, mid-count reset
    tab8.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tab8.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0));
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 0, 2, 3, 0));
    tab8.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tab8.push_back(mk(0, 0, 0, 1, 6, 1, 0, 6, 5, 0));
`ifdef CONTADOR_SAT_EN
    // Saturation at the power-of-two modulus
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 0, 7, 4, 0));
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 1, 7, 4, 0));
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 1, 7, 4, 0));
    tab8.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 1, 0));
    tab8.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tab8.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
`else
    // Wrap both ways at the power-of-two modulus
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 0, 7, 4, 0));
    tab8.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 1));
    tab8.push_back(mk(0, 1, 0, 0, 0, 1, 1, 7, 4, 1));
    tab8.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7, 4, 0));
`endif

`ifndef CONTADOR_SAT_EN
    // MODULUS=6: up wrap, down wrap, direction flip
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 2, 3, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 3, 2, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 5, 7, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 1));
    tab6.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0));
    tab6.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tab6.push_back(mk(0, 1, 0, 0, 0, 1, 1, 5, 7, 1));
    tab6.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 1));
    tab6.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
`endif
    // MODULUS=6: load (in range, clamped, over en at terminal), hold, Gray
    tab6.push_back(mk(0, 1, 1, 1, 3, 1, 0, 3, 2, 0));
    tab6.push_back(mk(0, 0, 1, 1, 7, 1, 0, 5, 7, 0));
    tab6.push_back(mk(0, 1, 1, 1, 6, 1, 1, 5, 7, 0));
    tab6.push_back(mk(0, 0, 0, 1, 4, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 6, 0));
    tab6.push_back(mk(0, 1, 0, 0, 0, 1, 0, 3, 2, 0));
    tab6.push_back(mk(0, 0, 0, 1, 5, 1, 0, 5, 7, 0));
    tab6.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0));

    foreach (tab8[i]) run_vec(1'b1, "m8", i, tab8[i]);
    foreach (tab6[i]) run_vec(1'b0, "m6", i, tab6[i]);

    // Hand sequence: reset while MODULUS=6 counter is mid-count, then resume
    run_vec(1'b0, "m6_rst", 0, mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0));
    run_vec(1'b0, "m6_rst", 1, mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    run_vec(1'b0, "m6_rst", 2, mk(0, 1, 1, 0, 0, 1, 0, 1, 1, 0));

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expected entries left, expected 0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
